rx_buffer_fifo_8word: RTL and testbench

RX_BUFFER_FIFO_8WORD -- requirements
Module: rx_buffer_fifo_8word

---
 rtl/rx_buffer_fifo_8word.sv | 66 ++++++
 tb/tb_rx_buffer_fifo_8word.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rx_buffer_fifo_8word.sv
// rx_buffer_fifo_8word: 8-slot receive FIFO with a registered output stage (9 words total).
// Define RX_FIFO_DROP_OLDEST_EN to overwrite the oldest stored word on overflow instead of dropping din.
module rx_buffer_fifo_8word #(
    parameter int WIDTH    = 400,
    parameter int AF_LEVEL = 6
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [3:0]       words_used,
    output logic             almost_full,
    output logic             overflow
);
    logic [WIDTH-1:0] mem [8];
    logic [3:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, used_nxt;
    logic empty, full, pop, xfer, wr_en, ovf, drop;

    always_comb begin
        empty    = wr_ptr == rd_ptr;
        full     = (wr_ptr[3] != rd_ptr[3]) && (wr_ptr[2:0] == rd_ptr[2:0]);
        pop      = dout_valid & dout_ready;
        xfer     = !empty && (!dout_valid || pop);
        // a transfer frees a slot on the same edge, so a full storage can still accept
        wr_en    = din_valid && (!full || xfer);
        ovf      = din_valid && full && !xfer;
`ifdef RX_FIFO_DROP_OLDEST_EN
        drop     = ovf;
`else
        drop     = 1'b0;
`endif
        wr_nxt   = wr_ptr + {3'd0, wr_en | drop};
        rd_nxt   = rd_ptr + {3'd0, xfer | drop};
        used_nxt = wr_nxt - rd_nxt;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            words_used  <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            words_used  <= used_nxt;
            almost_full <= used_nxt >= 4'(AF_LEVEL);
            overflow    <= ovf;
            // when full, the write slot equals the head slot; dout still captures the old head
            if (wr_en || drop) mem[wr_ptr[2:0]] <= din;
            if (xfer) begin
                dout       <= mem[rd_ptr[2:0]];
                dout_valid <= 1'b1;
            end else if (pop) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rx_buffer_fifo_8word.sv
// tb_rx_buffer_fifo_8word: directed checks of rx_buffer_fifo_8word, including overflow policy and async reset.
module tb_rx_buffer_fifo_8word;
    localparam int W = 400;
`ifdef RX_FIFO_DROP_OLDEST_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [3:0]   words_used;
    logic         almost_full;
    logic         overflow;
    int           n_cmp = 0;
    int           n_bad = 0;

    rx_buffer_fifo_8word #(.WIDTH(W), .AF_LEVEL(6)) dut (
        .clk(clk), .arst(arst), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .words_used(words_used), .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] e;
        int sent, cyc;
        #2;
        check("rst_dv", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_used", words_used, 0);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        step;
        arst = 1'b0;

        // single word latency
        dout_ready = 1'b1; din = W'(32'h01); din_valid = 1'b1;
        step;
        din_valid = 1'b0;
        check("t1_used", words_used, 1);
        check("t1_dv0", dout_valid, 0);
        step;
        check("t1_dv1", dout_valid, 1);
        check("t1_dout", dout, W'(32'h01));
        step;
        check("t1_dv2", dout_valid, 0);

        // fill 9 words with consumer stalled
        dout_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            din = W'(32'h10 + i); din_valid = 1'b1;
            step;
            check("t2_used", words_used, (i == 0) ? 1 : i);
            check("t2_af", almost_full, ((i == 0) ? 1 : i) >= 6);
            check("t2_ovf", overflow, 0);
        end
        din_valid = 1'b0;
        check("t2_dout", dout, W'(32'h10));
        check("t2_dv", dout_valid, 1);

        // overflow
        din = W'(32'h19); din_valid = 1'b1;
        step;
        din_valid = 1'b0;
        check("t3_ovf1", overflow, 1);
        check("t3_used", words_used, 8);
        step;
        check("t3_ovf0", overflow, 0);
        dout_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = (DROP && i != 0) ? W'(32'h11 + i) : W'(32'h10 + i);
            check("t3_dv", dout_valid, 1);
            check("t3_drain", dout, e);
            step;
        end
        check("t3_dv_end", dout_valid, 0);
        check("t3_used_end", words_used, 0);
        dout_ready = 1'b0;

        // full storage with simultaneous write and pop
        for (int i = 0; i < 9; i++) begin
            din = W'(32'h20 + i); din_valid = 1'b1;
            step;
        end
        check("t4_used_full", words_used, 8);
        check("t4_dv_full", dout_valid, 1);
        dout_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = W'(32'h29 + k); din_valid = 1'b1;
            check("t4_stream", dout, W'(32'h20 + k));
            step;
            check("t4_ovf", overflow, 0);
            check("t4_used", words_used, 8);
        end
        din_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("t4_dv", dout_valid, 1);
            check("t4_drain", dout, W'(32'h34 + i));
            step;
        end
        check("t4_dv_end", dout_valid, 0);
        dout_ready = 1'b0;

        // random consumer stalls across pointer wraps
        sent = 0; cyc = 0;
        while ((sent < 40 || q.size() > 0) && cyc < 2000) begin
            dout_ready = 1'($urandom_range(0, 1));
            din_valid = (sent < 40) && (q.size() < 9) && ($urandom_range(0, 3) != 0);
            din = W'(32'h100 + sent);
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) check("t5_spurious", dout_valid, 0);
                else check("t5_order", dout, q.pop_front());
            end
            if (din_valid) begin
                q.push_back(din);
                sent++;
            end
            step;
            cyc++;
            check("t5_ovf", overflow, 0);
        end
        check("t5_done", (sent == 40) && (q.size() == 0), 1);
        check("t5_dv_end", dout_valid, 0);
        din_valid = 1'b0; dout_ready = 1'b0;

        // async reset mid-stream
        for (int i = 0; i < 5; i++) begin
            din = W'(32'h30 + i); din_valid = 1'b1;
            step;
        end
        din_valid = 1'b0;
        check("t6_used_pre", words_used, 4);
        check("t6_dv_pre", dout_valid, 1);
        #2;
        arst = 1'b1;
        #1;
        check("t6_dv_rst", dout_valid, 0);
        check("t6_used_rst", words_used, 0);
        check("t6_af_rst", almost_full, 0);
        step;
        arst = 1'b0;
        din = W'(32'hAA); din_valid = 1'b1;
        step;
        din_valid = 1'b0;
        check("t6_used_aa", words_used, 1);
        check("t6_dv0", dout_valid, 0);
        step;
        check("t6_dv1", dout_valid, 1);
        check("t6_dout", dout, W'(32'hAA));
        dout_ready = 1'b1;
        step;
        check("t6_dv_end", dout_valid, 0);
        check("t6_used_end", words_used, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
